fetch_align: RTL

- Realigns 32-bit word-aligned fetch responses into whole RV32IMC instructions: 16-bit compressed, or 32-bit possibly straddling two fetch words.
- Sits between the fetch unit and the decode stage.
- Decode consumes the aligned instruction word, from which it slices the immediate field and immediate select feeding the immediate generator.
- Tracks the PC of every emitted instruction and handles redirects (flushes) to halfword-aligned targets.

---
 rtl/tcore_param.sv | 11 +
 rtl/fetch_align.sv | 104 ++++++++++
 2 files changed

// File: rtl/tcore_param.sv
// Core-wide parameters and shared types, including the fetch parcel record
// used by the instruction realigner.
package tcore_param;
    localparam int XLEN     = 32;
    localparam int FA_DEPTH = 4;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } fetch_parcel_t;
endpackage

// File: rtl/fetch_align.sv
// Realigns word-aligned fetch responses into whole RV32IMC instructions
// (16-bit compressed or 32-bit, possibly straddling two fetch words).
module fetch_align
    import tcore_param::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    input  logic            fetch_valid_i,
    output logic            fetch_ready_o,
    input  logic [31:0]     fetch_data_i,
    input  logic            fetch_err_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            inst_compressed_o,
    output logic            inst_err_o
);

    fetch_parcel_t   mem_q [FA_DEPTH];
    logic [1:0]      head_q, head_d;
    logic [2:0]      count_q, count_d;
    logic            skip_q, skip_d;
    logic [XLEN-1:0] pc_q, pc_d;

    fetch_parcel_t   hd, nx;
    logic            head_short, valid, accept, consume;
    logic [2:0]      push_n, pop_n;
    logic [1:0]      tail;
    logic            unused_pc0;

    assign unused_pc0 = flush_pc_i[0];

    // A faulted head parcel is emitted alone, whatever its encoding bits say.
    assign hd         = mem_q[head_q];
    assign nx         = mem_q[head_q + 2'd1];
    assign head_short = hd.err || (hd.data[1:0] != 2'b11);
    assign valid      = (count_q != 3'd0) && (head_short || count_q >= 3'd2);

    assign fetch_ready_o     = (count_q <= 3'd2);
    assign inst_valid_o      = valid;
    assign inst_o            = !valid    ? 32'h0 :
                               head_short ? {16'h0, hd.data} : {nx.data, hd.data};
    assign inst_compressed_o = valid && head_short;
    assign inst_err_o        = valid && (hd.err || (!head_short && nx.err));
    assign inst_pc_o         = pc_q;

    assign accept  = fetch_valid_i && fetch_ready_o && !flush_i;
    assign consume = valid && inst_ready_i;
    assign push_n  = !accept  ? 3'd0 : (skip_q ? 3'd1 : 3'd2);
    assign pop_n   = !consume ? 3'd0 : (head_short ? 3'd1 : 3'd2);
    assign tail    = head_q + count_q[1:0];

    always_comb begin
        head_d  = head_q;
        count_d = count_q;
        skip_d  = skip_q;
        pc_d    = pc_q;
        if (flush_i) begin
            head_d  = 2'd0;
            count_d = 3'd0;
            skip_d  = flush_pc_i[1];
            pc_d    = {flush_pc_i[XLEN-1:1], 1'b0};
        end else begin
            head_d  = head_q + pop_n[1:0];
            count_d = count_q + push_n - pop_n;
            if (accept)
                skip_d = 1'b0;
            if (consume)
                pc_d = pc_q + (head_short ? 32'd2 : 32'd4);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= 2'd0;
            count_q <= 3'd0;
            skip_q  <= RESET_PC[1];
            pc_q    <= RESET_PC;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
            skip_q  <= skip_d;
            pc_q    <= pc_d;
        end
    end

    // Slots at tail are free whenever a word is accepted (count <= 2).
    always_ff @(posedge clk_i) begin
        if (accept) begin
            if (skip_q) begin
                mem_q[tail] <= fetch_parcel_t'{data: fetch_data_i[31:16], err: fetch_err_i};
            end else begin
                mem_q[tail]        <= fetch_parcel_t'{data: fetch_data_i[15:0],  err: fetch_err_i};
                mem_q[tail + 2'd1] <= fetch_parcel_t'{data: fetch_data_i[31:16], err: fetch_err_i};
            end
        end
    end

endmodule
